// File: rtl/fir_decim_scaler.sv
// Decimating accumulate-and-scale stage behind the FIR: sums DECIM samples, rounds, rescales
// and buffers results in a 2-entry FIFO. Define DECIM_SAT_EN for saturation plus the ovf flag.
module fir_decim_scaler #(
    parameter int IN_W     = 30,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 14,
    parameter int DECIM    = 8,
    parameter int FILL_CNT = 35
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic signed [IN_W-1:0]  din,
    input  logic                    en,
    input  logic                    clr,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
`ifdef DECIM_SAT_EN
    output logic                    ovf,
`endif
    output logic                    drop
);

    localparam int LOG_D  = $clog2(DECIM);
    localparam int ACC_W  = IN_W + LOG_D;
    localparam int S      = SHIFT + LOG_D;
    localparam int FILL_W = $clog2(FILL_CNT + 1);

    localparam logic signed [ACC_W:0] RND_C = {{ACC_W{1'b0}}, 1'b1} << (S - 1);

    typedef enum logic {StFill, StRun} state_e;

    state_e                  state_q, state_d;
    logic [FILL_W-1:0]       fill_q, fill_d;
    logic [LOG_D-1:0]        phase_q, phase_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, sum;
    logic signed [ACC_W:0]   rnd;
    logic signed [OUT_W-1:0] res;
    logic                    push, pop, push_ok, set_drop;
    logic signed [OUT_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]              count_q, count_d;
    logic                    drop_q, drop_d;

    // FSM state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill: begin
                if (!en) begin
                    state_d = StFill;
                end else if (fill_q == FILL_W'(FILL_CNT - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!en) begin
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_comb begin
        push = (state_q == StRun) && en && (phase_q == LOG_D'(DECIM - 1));
    end

    // Counters and accumulator all collapse to zero whenever en is low
    always_comb begin
        fill_d  = '0;
        phase_d = '0;
        acc_d   = '0;
        if (en) begin
            unique case (state_q)
                StFill: fill_d = (fill_q == FILL_W'(FILL_CNT - 1)) ? '0 : fill_q + 1'b1;
                StRun: begin
                    phase_d = phase_q + 1'b1;
                    acc_d   = push ? '0 : sum;
                end
                default: fill_d = '0;
            endcase
        end
    end

    // One extra bit so the rounding offset cannot overflow a full-scale sum
    always_comb begin
        sum = acc_q + $signed({{LOG_D{din[IN_W-1]}}, din});
        rnd = $signed({sum[ACC_W-1], sum}) + RND_C;
    end

`ifdef DECIM_SAT_EN
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [ACC_W:0] shifted;
    logic                  sat_hi, sat_lo, ovf_q, ovf_d;

    always_comb begin
        shifted = rnd >>> S;
        sat_hi  = shifted > SAT_MAX;
        sat_lo  = shifted < SAT_MIN;
        if (sat_hi) begin
            res = {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (sat_lo) begin
            res = {1'b1, {(OUT_W - 1){1'b0}}};
        end else begin
            res = shifted[OUT_W-1:0];
        end
        ovf_d = (push && (sat_hi || sat_lo)) || (ovf_q && !clr);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    always_comb begin
        res = OUT_W'(rnd >>> S);
    end
`endif

    // Two-entry output FIFO; no bypass, so a push into an empty FIFO shows up next cycle
    always_comb begin
        dout_valid = (count_q != 2'd0);
        dout       = head_q;
        pop        = dout_valid && dout_ready;
        push_ok    = push && ((count_q != 2'd2) || pop);
        set_drop   = push && !push_ok;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        unique case ({push_ok, pop})
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = res;
                end else begin
                    tail_d = res;
                end
                count_d = count_q + 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = res;
                end else begin
                    head_d = tail_q;
                    tail_d = res;
                end
            end
            default: count_d = count_q;
        endcase
        drop_d = set_drop || (drop_q && !clr);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fill_q  <= '0;
            phase_q <= '0;
            acc_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            fill_q  <= fill_d;
            phase_q <= phase_d;
            acc_q   <= acc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    assign drop = drop_q;

endmodule

// File: tb/tb_fir_decim_scaler.sv
// Directed bench for fir_decim_scaler: vector table of constant inputs plus hand-built
// sequences for back-pressure/drop, mid-frame reset and an en glitch.
module tb_fir_decim_scaler;

    logic               clk;
    logic               n_rst;
    logic signed [29:0] din;
    logic               en;
    logic               clr;
    logic signed [15:0] dout;
    logic               dout_valid;
    logic               dout_ready;
    logic               drop;
`ifdef DECIM_SAT_EN
    logic               ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fir_decim_scaler dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .din        (din),
        .en         (en),
        .clr        (clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
`ifdef DECIM_SAT_EN
        .ovf        (ovf),
`endif
        .drop       (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [29:0] din;
        int                 exp_dout;
        bit                 exp_ovf;
        string              name;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        do begin
            step();
            edges++;
        end while (!dout_valid && edges < 200);
    endtask

    task automatic do_reset();
        n_rst      = 1'b0;
        en         = 1'b0;
        clr        = 1'b0;
        dout_ready = 1'b0;
        din        = '0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    initial begin
        int edges;
        vecs[0] = '{30'sd1638400,  100,    1'b0, "nominal"};
        vecs[1] = '{30'sd8192,     1,      1'b0, "round_up"};
        vecs[2] = '{30'sd8191,     0,      1'b0, "round_below"};
        vecs[3] = '{-30'sd8192,    0,      1'b0, "round_neg_half"};
        vecs[4] = '{-30'sd8193,    -1,     1'b0, "round_neg_below"};
        vecs[5] = '{-30'sd1638400, -100,   1'b0, "negative"};
`ifdef DECIM_SAT_EN
        vecs[6] = '{30'sd536870911, 32767, 1'b1, "full_scale_sat"};
`else
        vecs[6] = '{30'sd536870911, -32768, 1'b0, "full_scale_wrap"};
`endif

        n_rst = 1'b0;
        en = 1'b0; clr = 1'b0; dout_ready = 1'b0; din = '0;
        #2;
        check("reset_dout", dout, 0);
        check("reset_valid", dout_valid, 0);
        check("reset_drop", drop, 0);
`ifdef DECIM_SAT_EN
        check("reset_ovf", ovf, 0);
`endif

        foreach (vecs[i]) begin
            do_reset();
            en = 1'b1; dout_ready = 1'b1; din = vecs[i].din;
            wait_valid(edges);
            check({vecs[i].name, "_latency"}, edges, 43);
            check({vecs[i].name, "_dout"}, dout, vecs[i].exp_dout);
`ifdef DECIM_SAT_EN
            check({vecs[i].name, "_ovf"}, ovf, vecs[i].exp_ovf);
`endif
            wait_valid(edges);
            check({vecs[i].name, "_period"}, edges, 8);
            check({vecs[i].name, "_dout2"}, dout, vecs[i].exp_dout);
        end

        // Back-pressure: 100 and 200 held, 300 dropped; clr collides with the drop
        do_reset();
        en = 1'b1;
        for (int e = 1; e <= 60; e++) begin
            din = (e <= 43) ? 30'sd1638400 : (e <= 51) ? 30'sd3276800 : 30'sd4915200;
            clr = (e >= 59);
            step();
            if (e == 43) check("bp_first_valid", dout_valid, 1);
            if (e == 51) check("bp_drop_before_full", drop, 0);
            if (e == 59) begin
                check("bp_drop_set_wins", drop, 1);
                check("bp_head_held", dout, 100);
            end
            if (e == 60) check("bp_drop_cleared", drop, 0);
        end
        clr = 1'b0; en = 1'b0; dout_ready = 1'b1;
        step();
        check("bp_drain_second_valid", dout_valid, 1);
        check("bp_drain_second", dout, 200);
        step();
        check("bp_drain_empty", dout_valid, 0);

        // Asynchronous reset at phase 5 of a frame while an output is pending
        do_reset();
        en = 1'b1; din = 30'sd1638400;
        repeat (48) step();
        check("mid_valid_before", dout_valid, 1);
        n_rst = 1'b0;
        #1;
        check("mid_rst_dout", dout, 0);
        check("mid_rst_valid", dout_valid, 0);
        check("mid_rst_drop", drop, 0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        wait_valid(edges);
        check("mid_rst_refill", edges, 43);
        check("mid_rst_dout_after", dout, 100);

        // en glitch in RUN: pending entry still pops, then a full refill
        do_reset();
        en = 1'b1; din = 30'sd1638400;
        wait_valid(edges);
        step();
        step();
        en = 1'b0; dout_ready = 1'b1;
        step();
        check("en_glitch_pop", dout_valid, 0);
        en = 1'b1;
        wait_valid(edges);
        check("en_glitch_refill", edges, 43);
        check("en_glitch_dout", dout, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
